// File: rtl/seek_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : seek_sequencer
// Brief    : Track-level seek / recalibrate sequencer. Splits each head move
//            into step-controller commands of at most 128 pulses, tracks the
//            current cylinder, waits for head settle and reports DONE/ERROR.
// Revision : 1.0  initial release
// ============================================================================
module seek_sequencer #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int RECAL_CHUNKS  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       seek_req_i,
  input  logic       recal_req_i,
  input  logic [7:0] target_track_i,
  input  logic       is_stepping_i,
  input  logic       track0_hit_i,
  output logic [7:0] ctlbyte_o,
  output logic       write_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [7:0] cur_track_o,
  output logic       track_valid_o
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  CHUNK_MAX   = 8'(RECAL_CHUNKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAN   = 3'd1,
    S_ISSUE  = 3'd2,
    S_ARM    = 3'd3,
    S_WAIT   = 3'd4,
    S_CHECK  = 3'd5,
    S_SETTLE = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  state_t      state_q;
  logic [7:0]  ctlbyte_q;
  logic        write_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  cur_track_q;
  logic        track_valid_q;
  logic [7:0]  target_q;
  logic        recal_q;      // current phase is a recalibrate
  logic        pending_q;    // a seek follows the running recalibrate
  logic [7:0]  chunks_q;     // outward recalibrate commands issued so far
  logic [7:0]  k_q;          // pulses in the command in flight
  logic        dir_q;        // direction of the command in flight (1 = outward)
  logic [15:0] settle_q;

  logic        dir_d;
  logic [7:0]  dist_d;
  logic [7:0]  chunk_d;
  logic [6:0]  ctl_n_d;
  logic [7:0]  stepped_d;

  // Seek planning arithmetic: remaining distance, chunk size and head update
  always_comb begin
    dir_d     = (target_q < cur_track_q);
    dist_d    = dir_d ? (cur_track_q - target_q) : (target_q - cur_track_q);
    chunk_d   = (dist_d > 8'd128) ? 8'd128 : dist_d;
    ctl_n_d   = (dist_d > 8'd128) ? 7'h7F : 7'(dist_d - 8'd1);
    stepped_d = dir_q ? (cur_track_q - k_q) : (cur_track_q + k_q);
  end

  // Sequencer state machine with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      ctlbyte_q     <= 8'd0;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cur_track_q   <= 8'd0;
      track_valid_q <= 1'b0;
      target_q      <= 8'd0;
      recal_q       <= 1'b0;
      pending_q     <= 1'b0;
      chunks_q      <= 8'd0;
      k_q           <= 8'd0;
      dir_q         <= 1'b0;
      settle_q      <= 16'd0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (recal_req_i) begin
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            recal_q   <= 1'b1;
            pending_q <= 1'b0;
            chunks_q  <= 8'd0;
            state_q   <= S_PLAN;
          end else if (seek_req_i) begin
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            target_q  <= target_track_i;
            // An unknown position forces a recalibrate ahead of the seek
            recal_q   <= ~track_valid_q;
            pending_q <= ~track_valid_q;
            chunks_q  <= 8'd0;
            state_q   <= S_PLAN;
          end
        end
        S_PLAN: begin
          if (recal_q) begin
            ctlbyte_q <= 8'hFF;
            k_q       <= 8'd128;
            dir_q     <= 1'b1;
            chunks_q  <= chunks_q + 8'd1;
            write_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end else if (dist_d == 8'd0) begin
            state_q <= S_FINISH;
          end else begin
            ctlbyte_q <= {dir_d, ctl_n_d};
            k_q       <= chunk_d;
            dir_q     <= dir_d;
            write_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE:  state_q <= S_ARM;
        S_ARM:    state_q <= S_WAIT;
        S_WAIT: begin
          if (!is_stepping_i) state_q <= S_CHECK;
        end
        S_CHECK: begin
          settle_q <= 16'd0;
          if (recal_q) begin
            if (track0_hit_i) begin
              cur_track_q   <= 8'd0;
              track_valid_q <= 1'b1;
              recal_q       <= 1'b0;
              pending_q     <= 1'b0;
              state_q       <= pending_q ? S_PLAN : S_SETTLE;
            end else if (chunks_q < CHUNK_MAX) begin
              state_q <= S_PLAN;
            end else begin
              error_q       <= 1'b1;
              track_valid_q <= 1'b0;
              pending_q     <= 1'b0;
              state_q       <= S_FINISH;
            end
          end else if (dir_q && track0_hit_i) begin
            // Track 0 reached before the planned end: resynchronise and fail
            cur_track_q <= 8'd0;
            error_q     <= 1'b1;
            state_q     <= S_FINISH;
          end else begin
            cur_track_q <= stepped_d;
            state_q     <= (stepped_d == target_q) ? S_SETTLE : S_PLAN;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= S_FINISH;
          else                         settle_q <= settle_q + 16'd1;
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          recal_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctlbyte_o     = ctlbyte_q;
  assign write_o       = write_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign cur_track_o   = cur_track_q;
  assign track_valid_o = track_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seek_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seek_sequencer
// Brief    : Self-checking bench for seek_sequencer with a step-controller
//            plant model and an arithmetic reference model of each operation.
// Revision : 1.0  initial release
// ============================================================================
module tb_seek_sequencer;

  localparam int SETTLE = 1000;
  localparam int RCH    = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       seek_req_i = 1'b0;
  logic       recal_req_i = 1'b0;
  logic [7:0] target_track_i = 8'd0;
  logic       is_stepping_i = 1'b0;
  logic       track0_hit_i = 1'b0;
  logic [7:0] ctlbyte_o;
  logic       write_o, busy_o, done_o, error_o, track_valid_o;
  logic [7:0] cur_track_o;

  seek_sequencer #(.SETTLE_CYCLES(SETTLE), .RECAL_CHUNKS(RCH)) dut (
    .clk_i(clk), .rst_i(rst_i), .seek_req_i(seek_req_i), .recal_req_i(recal_req_i),
    .target_track_i(target_track_i), .is_stepping_i(is_stepping_i),
    .track0_hit_i(track0_hit_i), .ctlbyte_o(ctlbyte_o), .write_o(write_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .cur_track_o(cur_track_o), .track_valid_o(track_valid_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Plant: physical head position and step controller behaviour
  int phys = 40;
  bit no_hit = 0;
  int rem = 0;
  bit pend = 0;
  bit res = 0;
  int moved;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write_o) begin
      if (ctlbyte_o[7]) begin
        moved = (phys < int'(ctlbyte_o[6:0]) + 1) ? phys : int'(ctlbyte_o[6:0]) + 1;
        phys  = phys - moved;
        res   = !no_hit && (phys == 0);
      end else begin
        moved = int'(ctlbyte_o[6:0]) + 1;
        phys  = phys + moved;
        res   = 1'b0;
      end
      rem = (moved == 0) ? 1 : moved;
      pend = 0;
      is_stepping_i <= 1'b1;
      track0_hit_i  <= 1'b0;
    end else if (is_stepping_i) begin
      rem = rem - 1;
      if (rem == 0) begin
        is_stepping_i <= 1'b0;
        pend = 1;
      end
    end else if (pend) begin
      track0_hit_i <= res;
      pend = 0;
    end
  end

  // Monitor: capture strobed command bytes and DONE pulses
  int cap[$];
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (write_o) begin
      cap.push_back(int'(ctlbyte_o));
      last_wr_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model of the host-visible outcome of one operation
  int m_cur = 0;
  bit m_valid = 0;
  int exp_q[$];
  int exp_cur;
  bit exp_valid, exp_err;

  task automatic predict(input bit is_recal, input int tgt);
    int ph;
    bit ok;
    bit dir;
    int d, k;
    ph = phys;
    exp_q.delete();
    exp_err = 0;
    ok = 1;
    if (is_recal || !m_valid) begin
      ok = 0;
      for (int c = 0; c < RCH && !ok; c++) begin
        exp_q.push_back(8'hFF);
        ph = (ph > 128) ? ph - 128 : 0;
        if (!no_hit && ph == 0) ok = 1;
      end
      if (ok) begin m_cur = 0; m_valid = 1; end
      else begin exp_err = 1; m_valid = 0; end
    end
    if (ok && !is_recal) begin
      while (m_cur != tgt) begin
        dir = (tgt < m_cur);
        d = dir ? m_cur - tgt : tgt - m_cur;
        k = (d > 128) ? 128 : d;
        exp_q.push_back((dir ? 128 : 0) + k - 1);
        if (dir) begin
          ph = (ph > k) ? ph - k : 0;
          if (ph == 0 && !no_hit) begin
            m_cur = 0;
            exp_err = 1;
            break;
          end
          m_cur = m_cur - k;
        end else begin
          ph = ph + k;
          m_cur = m_cur + k;
        end
      end
    end
    exp_cur = m_cur;
    exp_valid = m_valid;
  endtask

  // kind: 0 = seek, 1 = recalibrate, 2 = both requests together
  task automatic run_op(input string tag, input int kind, input int tgt, output int lat);
    int n;
    predict(kind != 0, tgt);
    cap.delete();
    done_cnt = 0;
    @(negedge clk);
    target_track_i = 8'(tgt);
    seek_req_i  = (kind != 1);
    recal_req_i = (kind != 0);
    @(posedge clk); #1;
    seek_req_i  = 1'b0;
    recal_req_i = 1'b0;
    chk({tag, "_busy_accept"}, busy_o, 1);
    n = 0;
    while (!done_o && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    chk({tag, "_done_seen"}, done_o, 1);
    chk({tag, "_busy_at_done"}, busy_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_strobes"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      chk({tag, "_ctlbyte"}, cap[i], exp_q[i]);
    chk({tag, "_cur"}, cur_track_o, exp_cur);
    chk({tag, "_valid"}, track_valid_o, exp_valid);
    chk({tag, "_error"}, error_o, exp_err);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, ctlbyte_o, 0);
    chk({tag, "_wr"}, write_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, error_o, 0);
    chk({tag, "_cur"}, cur_track_o, 0);
    chk({tag, "_valid"}, track_valid_o, 0);
  endtask

  initial begin
    int lat;
    int t;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // Recalibrate from 40 tracks out; settle time follows the single strobe
    phys = 40;
    run_op("recal40", 1, 0, lat);
    chk("recal40_settle_gap", done_cyc - last_wr_cyc, 40 + SETTLE + 4);

    run_op("seek200", 0, 200, lat);
    run_op("seek190", 0, 190, lat);
    run_op("seek_zero", 0, 190, lat);
    chk("seek_zero_latency", lat, 2);

    // Drive never reports track 0
    no_hit = 1;
    run_op("recal_fail", 1, 0, lat);
    no_hit = 0;

    // Seek with unknown position: recalibrate then seek
    run_op("seek5_invalid", 0, 5, lat);

    // Recalibrate wins over a simultaneous seek
    run_op("both_req", 2, 77, lat);

    // Randomised seeks, every fourth one to the current track
    for (int i = 0; i < 12; i++) begin
      t = (i % 4 == 3) ? m_cur : int'($urandom_range(1, 255));
      run_op("rand_seek", 0, t, lat);
      if (t == m_cur && exp_q.size() == 0) chk("rand_zero_latency", lat, 2);
    end

    // Head slipped outward: track 0 arrives before the planned end
    run_op("seek120", 0, 120, lat);
    phys = 50;
    run_op("early_t0", 0, 20, lat);
    run_op("after_resync", 0, 3, lat);

    // Reset while the sequencer waits on the controller
    cap.delete();
    @(negedge clk);
    target_track_i = 8'd250;
    seek_req_i = 1'b1;
    @(negedge clk);
    seek_req_i = 1'b0;
    t = 0;
    while (!is_stepping_i && t < 50) begin @(negedge clk); t++; end
    chk("rst_wait_reached", is_stepping_i, 1);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    cap.delete();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    m_cur = 0;
    m_valid = 0;
    repeat (300) @(negedge clk);
    chk("rst_no_strobe", cap.size(), 0);
    chk("rst_idle_busy", busy_o, 0);
    t = 0;
    while ((is_stepping_i || pend) && t < 500) begin @(negedge clk); t++; end
    run_op("recal_after_rst", 1, 0, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
